// File: rtl/trig_info_decoder.sv
// trig_info_decoder: rebuilds {event ID, BCID} records from the strobed trigger-info stream
// and queues them in a show-ahead FIFO with framing, continuity and drop accounting.
module trig_info_decoder #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     l1a,
    input  logic [11:0]              bCnt,
    input  logic                     bCntStr,
    input  logic                     evCntLStr,
    input  logic                     evCntHStr,
    output logic                     evValid,
    input  logic                     evReady,
    output logic [23:0]              evId,
    output logic [11:0]              evBcid,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic [7:0]               dropCnt,
    output logic [7:0]               frameErrCnt,
    output logic                     seqErr
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, HAVE_BC, HAVE_EVL} state_t;

    state_t         state_q, state_d;
    logic [11:0]    bcid_q, bcid_d, evlo_q, evlo_d;
    logic [23:0]    last_q;
    logic           have_last_q, seq_q;
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    count_q, count_d;
    logic [7:0]     drop_q, ferr_q;
    logic [35:0]    mem [DEPTH];
    logic [35:0]    head;
    logic [23:0]    new_id;
    logic           multi, start, only_l, only_h, frame_err, push, pop, wr_en, drop;

    assign multi  = (bCntStr & evCntLStr) | (bCntStr & evCntHStr) | (evCntLStr & evCntHStr);
    assign start  = bCntStr & l1a & ~multi;
    assign only_l = evCntLStr & ~bCntStr & ~evCntHStr;
    assign only_h = evCntHStr & ~bCntStr & ~evCntLStr;
    assign new_id = {bCnt, evlo_q};

    // A fresh l1a-qualified BCID always wins: it aborts any partial frame and restarts.
    always_comb begin
        state_d   = state_q;
        bcid_d    = bcid_q;
        evlo_d    = evlo_q;
        frame_err = 1'b0;
        push      = 1'b0;
        if (multi) begin
            state_d   = IDLE;
            frame_err = 1'b1;
        end else if (start) begin
            state_d   = HAVE_BC;
            bcid_d    = bCnt;
            frame_err = state_q != IDLE;
        end else begin
            case (state_q)
                IDLE:    frame_err = bCntStr | evCntLStr | evCntHStr;
                HAVE_BC: begin
                    state_d   = only_l ? HAVE_EVL : IDLE;
                    evlo_d    = only_l ? bCnt : evlo_q;
                    frame_err = ~only_l;
                end
                default: begin
                    state_d   = IDLE;
                    push      = only_h;
                    frame_err = ~only_h;
                end
            endcase
        end
    end

    assign pop     = evValid & evReady;
    assign wr_en   = push & ((count_q != DEPTH[AW:0]) | pop);
    assign drop    = push & ~wr_en;
    assign count_d = (wr_en & ~pop) ? count_q + 1'b1 :
                     (pop & ~wr_en) ? count_q - 1'b1 : count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bcid_q      <= '0;
            evlo_q      <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
            seq_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            ferr_q      <= '0;
        end else begin
            state_q <= state_d;
            bcid_q  <= bcid_d;
            evlo_q  <= evlo_d;
            if (push) begin
                seq_q       <= seq_q | (have_last_q & (new_id != last_q + 24'd1));
                last_q      <= new_id;
                have_last_q <= 1'b1;
            end
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (frame_err && ferr_q != 8'hFF) ferr_q <= ferr_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= {new_id, bcid_q};
    end

    assign head        = mem[rd_q];
    assign evValid     = count_q != '0;
    assign evId        = evValid ? head[35:12] : '0;
    assign evBcid      = evValid ? head[11:0] : '0;
    assign fifoCount   = count_q;
    assign dropCnt     = drop_q;
    assign frameErrCnt = ferr_q;
    assign seqErr      = seq_q;
endmodule

// File: tb/tb_trig_info_decoder.sv
// tb_trig_info_decoder: directed checks of framing, continuity, FIFO and reset behaviour.
module tb_trig_info_decoder;
    logic        clk = 1'b0;
    logic        rstn, l1a, bCntStr, evCntLStr, evCntHStr, evReady, evValid, seqErr;
    logic [11:0] bCnt, evBcid;
    logic [23:0] evId;
    logic [3:0]  fifoCount;
    logic [7:0]  dropCnt, frameErrCnt;
    int          checks = 0;
    int          errors = 0;
    int          exp_ids [8] = '{24'h4C7, 24'h4C8, 24'h4C9, 24'h4CA, 24'h4CB, 24'h4CC, 24'h4CD, 24'h4D0};

    trig_info_decoder #(.DEPTH(8)) dut (
        .clk(clk), .rstn(rstn), .l1a(l1a), .bCnt(bCnt), .bCntStr(bCntStr),
        .evCntLStr(evCntLStr), .evCntHStr(evCntHStr), .evValid(evValid), .evReady(evReady),
        .evId(evId), .evBcid(evBcid), .fifoCount(fifoCount), .dropCnt(dropCnt),
        .frameErrCnt(frameErrCnt), .seqErr(seqErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic l, input logic h, input logic [11:0] d);
        l1a = a; bCntStr = b; evCntLStr = l; evCntHStr = h; bCnt = d;
        @(posedge clk); #1;
        l1a = 0; bCntStr = 0; evCntLStr = 0; evCntHStr = 0; bCnt = '0;
    endtask

    task automatic frame(input logic [11:0] bc, input logic [23:0] id);
        drive(1, 1, 0, 0, bc);
        drive(0, 0, 1, 0, id[11:0]);
        drive(0, 0, 0, 1, id[23:12]);
    endtask

    task automatic do_reset();
        rstn = 0; #3; rstn = 1;
    endtask

    initial begin
        rstn = 0; evReady = 0;
        l1a = 0; bCntStr = 0; evCntLStr = 0; evCntHStr = 0; bCnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", evValid, 0);
        chk("rst_count", fifoCount, 0);
        chk("rst_drop", dropCnt, 0);
        chk("rst_ferr", frameErrCnt, 0);
        chk("rst_seq", seqErr, 0);
        chk("rst_id", evId, 0);
        rstn = 1;
        @(posedge clk); #1;

        frame(12'h5FD, 24'h0004C6);
        chk("single_valid", evValid, 1);
        chk("single_bcid", evBcid, 12'h5FD);
        chk("single_id", evId, 24'h0004C6);
        evReady = 1;
        @(posedge clk); #1;
        evReady = 0;
        chk("single_popped", evValid, 0);

        do_reset();
        for (int i = 0; i < 10; i++) frame(12'h100 + 12'(i), 24'h0004C6 + 24'(i));
        chk("full_count", fifoCount, 8);
        chk("full_drop", dropCnt, 2);
        chk("full_seq", seqErr, 0);
        chk("full_head", evId, 24'h0004C6);
        drive(1, 1, 0, 0, 12'h200);
        drive(0, 0, 1, 0, 12'h4D0);
        evReady = 1;
        drive(0, 0, 0, 1, 12'h000);
        evReady = 0;
        chk("pp_count", fifoCount, 8);
        chk("pp_drop", dropCnt, 2);
        chk("pp_seq", seqErr, 0);
        evReady = 1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", evValid, 1);
            chk("drain_id", evId, exp_ids[i]);
            @(posedge clk); #1;
        end
        evReady = 0;
        chk("drain_empty", evValid, 0);

        do_reset();
        frame(12'h001, 24'h000FFF);
        frame(12'h002, 24'h001000);
        chk("seq_wrap_ok", seqErr, 0);
        frame(12'h003, 24'h001002);
        chk("seq_gap", seqErr, 1);
        frame(12'h004, 24'h001003);
        chk("seq_sticky", seqErr, 1);

        do_reset();
        drive(1, 1, 0, 0, 12'h0AA);
        drive(0, 0, 0, 0, 12'h000);
        chk("ferr_missing_l", frameErrCnt, 1);
        chk("ferr_no_rec", fifoCount, 0);
        drive(1, 1, 0, 0, 12'h0BB);
        drive(0, 0, 1, 0, 12'h111);
        drive(1, 1, 0, 0, 12'h0CC);
        chk("ferr_abort", frameErrCnt, 2);
        drive(0, 0, 1, 0, 12'h222);
        drive(0, 0, 0, 1, 12'h033);
        chk("ferr_rec_count", fifoCount, 1);
        chk("ferr_rec_id", evId, 24'h033222);
        chk("ferr_rec_bcid", evBcid, 12'h0CC);
        chk("ferr_cnt_hold", frameErrCnt, 2);
        drive(0, 0, 0, 1, 12'h000);
        chk("ferr_lone_h", frameErrCnt, 3);
        drive(0, 1, 0, 0, 12'h000);
        chk("ferr_no_l1a", frameErrCnt, 4);
        drive(1, 1, 1, 0, 12'h000);
        chk("ferr_multi", frameErrCnt, 5);

        do_reset();
        drive(0, 0, 1, 0, 12'h000);
        frame(12'h010, 24'h000100);
        frame(12'h011, 24'h000101);
        frame(12'h012, 24'h000105);
        chk("mid_count", fifoCount, 3);
        chk("mid_ferr", frameErrCnt, 1);
        chk("mid_seq", seqErr, 1);
        drive(1, 1, 0, 0, 12'h020);
        drive(0, 0, 1, 0, 12'h777);
        rstn = 0; #1;
        chk("mid_rst_valid", evValid, 0);
        chk("mid_rst_count", fifoCount, 0);
        chk("mid_rst_ferr", frameErrCnt, 0);
        chk("mid_rst_drop", dropCnt, 0);
        chk("mid_rst_seq", seqErr, 0);
        #2; rstn = 1;
        @(posedge clk); #1;
        chk("mid_no_err", frameErrCnt, 0);
        frame(12'h321, 24'hABC123);
        chk("post_valid", evValid, 1);
        chk("post_id", evId, 24'hABC123);
        chk("post_bcid", evBcid, 12'h321);
        chk("post_count", fifoCount, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trig_info_decoder.md
# trig_info_decoder

Decodes the serial trigger-information stream produced by the L1A emulator. The stream carries a bunch-crossing ID and a 24-bit event counter, one 12-bit word per cycle under strobes. The block rebuilds each {event ID, BCID} record, checks strobe framing and event-ID continuity, and buffers the records in a small show-ahead FIFO. A valid/ready interface hands the records to the readout logic downstream.

## Interface
- DEPTH, 8, FIFO depth in records; power of two, 2..64
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- l1a  in  1  level-1 accept pulse
- bCnt  in  12  multiplexed word: BCID, then evCnt[11:0], then evCnt[23:12]
- bCntStr  in  1  bCnt holds BCID
- evCntLStr  in  1  bCnt holds event-counter low half
- evCntHStr  in  1  bCnt holds event-counter high half
- evValid  out  1  FIFO head record available
- evReady  in  1  consumer accepts head record when evValid & evReady
- evId  out  24  head record event ID
- evBcid  out  12  head record BCID
- fifoCount  out  log2(DEPTH)+1  records stored
- dropCnt  out  8  records lost to FIFO full; saturates at 255
- frameErrCnt  out  8  malformed frames; saturates at 255
- seqErr  out  1  sticky flag: event-ID discontinuity seen

## Operation
- Frame FSM states: IDLE, HAVE_BC, HAVE_EVL.
  - IDLE: on bCntStr & l1a, latch bcid = bCnt and go to HAVE_BC.
  - IDLE: bCntStr without l1a counts as a frame error; stay in IDLE.
  - IDLE: evCntLStr or evCntHStr alone counts as a frame error.
  - HAVE_BC: needs evCntLStr alone this cycle. If present, latch evLo = bCnt and go to HAVE_EVL. Otherwise go to IDLE and count a frame error.
  - HAVE_EVL: needs evCntHStr alone this cycle. If present, form the record {bCnt, evLo, bcid}, push it, and go to IDLE. Otherwise go to IDLE and count a frame error.
  - In HAVE_BC or HAVE_EVL, a bCntStr & l1a counts one frame error for the aborted frame. The FSM then restarts in HAVE_BC with the new BCID in the same cycle.
  - More than one strobe asserted in the same cycle is a frame error.
- Continuity check:
  - lastId and haveLast reset to 0.
  - On each completed record, if haveLast and newId != lastId + 1 (mod 2^24), set seqErr.
  - Then lastId = newId and haveLast = 1. The check runs even when the record is dropped.
- FIFO:
  - Show-ahead: evId and evBcid equal the head record whenever evValid = 1. They are don't-care otherwise.
  - Pop when evValid & evReady.
  - Push is accepted if fifoCount < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the record is discarded and dropCnt increments.
  - Pointers wrap modulo DEPTH. fifoCount never exceeds DEPTH.
- Counters are 8 bits and hold at 255. Frame errors and drops that occur in the same cycle each increment their own counter.
- Reset (asserted at any time, including mid-frame):
  - FSM returns to IDLE.
  - FIFO is emptied: evValid = 0, fifoCount = 0.
  - dropCnt = 0, frameErrCnt = 0, seqErr = 0, evId = 0, evBcid = 0.
  - The partial frame is discarded without counting an error.

## Timing
- Legal frame: cycle T has l1a & bCntStr, T+1 has evCntLStr, T+2 has evCntHStr.
- The record is written at the T+2 edge. evValid = 1 from cycle T+3 if the FIFO was empty.
- Back-to-back frames are legal: bCntStr at T+3 is accepted.
- Pop takes effect at the edge. Next head data is visible the cycle after.
- Push and pop in the same cycle: fifoCount is unchanged. When empty, the pushed record becomes head at the next cycle.
- seqErr, frameErrCnt and dropCnt update on the edge that ends the offending cycle.

## Test plan
- Single frame, bcid 0x5FD, low 0x4C6, high 0x000 -> evValid at T+3, evBcid = 0x5FD, evId = 0x0004C6. With evReady = 1, evValid drops at T+4.
- 10 back-to-back frames with IDs 0x0004C6..0x0004CF and evReady = 0, DEPTH = 8 -> fifoCount = 8, dropCnt = 2, seqErr = 0. Draining returns IDs 0x0004C6..0x0004CD in order.
- Frames with IDs 0x000FFF then 0x001000 -> seqErr = 0. A following ID of 0x001002 -> seqErr = 1, and it stays 1.
- Missing evCntLStr after bCntStr -> frameErrCnt = 1, no record. Then bCntStr during HAVE_EVL -> frameErrCnt = 2, and the new frame completes normally.
- rstn asserted in HAVE_EVL with 3 records queued -> evValid = 0, fifoCount = 0, all counters 0. The next legal frame decodes correctly.
- FIFO full, with a push and evReady = 1 in the same cycle -> record accepted, fifoCount stays 8, dropCnt unchanged.
